input_load_controller: RTL

Sequences an image load into the network's serial input shift register. On a start command it reads numInputs words of dataWidth bits from the image memory. It serializes each word MSB-first onto serialData/serialClock, then pulses pushBuffer once so the shifted vector is transferred to the parallel input buffer. It sits between the image memory and the input shift register, and it reports completion to the top-level network sequencer.

---
 rtl/nn_ctrl_pkg.sv | 22 ++
 rtl/serial_bit_tx.sv | 96 +++++++++
 rtl/input_load_controller.sv | 126 ++++++++++++
 3 files changed

// File: rtl/nn_ctrl_pkg.sv
// rtl/nn_ctrl_pkg.sv - shared load-sequencer state encoding, network defaults and counter width helper
package nn_ctrl_pkg;

    localparam int NN_NUM_INPUTS = 784;
    localparam int NN_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        WAIT     = 3'd2,
        SHIFT_LO = 3'd3,
        SHIFT_HI = 3'd4,
        PUSH     = 3'd5,
        DONE     = 3'd6
    } load_state_t;

    // Width needed to hold values 0..range_n-1, never narrower than one bit.
    function automatic int cnt_width(input int range_n);
        return (range_n <= 2) ? 1 : $clog2(range_n);
    endfunction

endpackage

// File: rtl/serial_bit_tx.sv
// rtl/serial_bit_tx.sv - MSB-first word serializer with divided, registered shift clock
module serial_bit_tx
    import nn_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = NN_DATA_WIDTH,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] word,
    output logic                  phase_end,
    output logic                  word_done,
    output logic                  serial_clock,
    output logic                  serial_data
);

    localparam int BIT_W = cnt_width(DATA_WIDTH);
    localparam int PH_W  = cnt_width(CLK_DIV + 1);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_MSB = BIT_W'(DATA_WIDTH - 1);

    logic                  active_q, active_d;
    logic                  hi_q, hi_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  data_q, data_d;

    always_comb begin
        active_d  = active_q;
        hi_d      = hi_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        word_d    = word_q;
        data_d    = data_q;
        phase_end = active_q && (phase_q == PH_LAST);
        word_done = phase_end && hi_q && (bit_q == '0);

        if (clear) begin
            active_d = 1'b0;
            hi_d     = 1'b0;
            phase_d  = '0;
            bit_d    = '0;
            word_d   = '0;
            data_d   = 1'b0;
        end else if (load) begin
            active_d = 1'b1;
            hi_d     = 1'b0;
            phase_d  = '0;
            bit_d    = BIT_MSB;
            word_d   = word;
            data_d   = word[DATA_WIDTH-1];
        end else if (active_q) begin
            if (!phase_end) begin
                phase_d = phase_q + 1'b1;
            end else begin
                phase_d = '0;
                if (!hi_q) begin
                    hi_d = 1'b1;
                end else if (bit_q != '0) begin
                    // Data only changes on the way into the low phase.
                    hi_d   = 1'b0;
                    bit_d  = bit_q - 1'b1;
                    data_d = word_q[bit_d];
                end else begin
                    hi_d     = 1'b0;
                    active_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            active_q <= 1'b0;
            hi_q     <= 1'b0;
            phase_q  <= '0;
            bit_q    <= '0;
            word_q   <= '0;
            data_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            hi_q     <= hi_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            word_q   <= word_d;
            data_q   <= data_d;
        end
    end

    assign serial_clock = hi_q;
    assign serial_data  = data_q;

endmodule

// File: rtl/input_load_controller.sv
// rtl/input_load_controller.sv - fetches image words and streams them into the input shift register
module input_load_controller
    import nn_ctrl_pkg::*;
#(
    parameter int numInputs = NN_NUM_INPUTS,
    parameter int dataWidth = NN_DATA_WIDTH,
    parameter int clkDiv    = 4,
    parameter int addrWidth = cnt_width(numInputs)
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    output logic [addrWidth-1:0] memAddr,
    output logic                 memRd,
    input  logic [dataWidth-1:0] memRdData,
    output logic                 serialClock,
    output logic                 serialData,
    output logic                 pushBuffer,
    output logic                 busy,
    output logic                 done
);

    localparam logic [addrWidth-1:0] LAST_WORD = addrWidth'(numInputs - 1);

    load_state_t          state_q, state_d;
    logic [addrWidth-1:0] word_idx_q, word_idx_d;
    logic [addrWidth-1:0] mem_addr_q, mem_addr_d;
    logic                 mem_rd_q, mem_rd_d;
    logic                 push_q, push_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cancel;
    logic                 tx_phase_end;
    logic                 tx_word_done;

    assign cancel = abort && (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d    = FETCH;
                    word_idx_d = '0;
                end
            end
            FETCH:    state_d = WAIT;
            WAIT:     state_d = SHIFT_LO;
            SHIFT_LO: begin
                if (tx_phase_end) state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (tx_word_done) begin
                    if (word_idx_q < LAST_WORD) begin
                        word_idx_d = word_idx_q + 1'b1;
                        state_d    = FETCH;
                    end else begin
                        state_d = PUSH;
                    end
                end else if (tx_phase_end) begin
                    state_d = SHIFT_LO;
                end
            end
            PUSH:     state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // Cancel overrides every transition, including the one into PUSH.
        if (cancel) begin
            state_d    = IDLE;
            word_idx_d = '0;
        end

        mem_rd_d   = (state_d == FETCH);
        push_d     = (state_d == PUSH);
        done_d     = (state_d == DONE);
        busy_d     = (state_d != IDLE);
        mem_addr_d = cancel ? '0 : ((state_d == FETCH) ? word_idx_d : mem_addr_q);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            push_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            push_q     <= push_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    serial_bit_tx #(
        .DATA_WIDTH (dataWidth),
        .CLK_DIV    (clkDiv)
    ) u_tx (
        .clk          (CLOCK_50),
        .resetn       (reset),
        .clear        (cancel),
        .load         (state_q == WAIT),
        .word         (memRdData),
        .phase_end    (tx_phase_end),
        .word_done    (tx_word_done),
        .serial_clock (serialClock),
        .serial_data  (serialData)
    );

    assign memAddr    = mem_addr_q;
    assign memRd      = mem_rd_q;
    assign pushBuffer = push_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
